bus_grant_fsm: RTL

- Downstream consumer of the four sorted channel addresses produced by the priority sorting stage of the bus arbiter.
- Issues a one-hot bus grant to one of four clients:
  - Scans the sorted addresses, highest priority first.
  - Chooses the first address whose client is requesting.
  - Holds the grant until the client releases it or a hold-limit timeout fires.
  - Inserts a one-cycle turnaround, then re-arbitrates.

---
 rtl/bus_grant_fsm.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_grant_fsm.sv
// Bus grant state machine: scans the sorted priority list, grants the first requesting client,
// and holds the grant until release or hold-limit timeout, then inserts a one-cycle turnaround.
module bus_grant_fsm #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] client_req,
   input  logic [1:0] first_priority_channel_addr,
   input  logic [1:0] second_priority_channel_addr,
   input  logic [1:0] third_priority_channel_addr,
   input  logic [1:0] fourth_priority_channel_addr,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic [1:0] grant_addr,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_next;
   logic [3:0]       mask;
   logic [3:0]       mask_next;
   logic [3:0]       grant_next;
   logic             grant_valid_next;
   logic [1:0]       grant_addr_next;
   logic             timeout_next;

   logic [3:0]       eff_req;
   logic [1:0]       winner;
   logic             hit;
   logic [1:0]       sorted_addr [4];

   assign sorted_addr[0] = first_priority_channel_addr;
   assign sorted_addr[1] = second_priority_channel_addr;
   assign sorted_addr[2] = third_priority_channel_addr;
   assign sorted_addr[3] = fourth_priority_channel_addr;

   // The mask only deflects a timed-out client when someone else is waiting.
   always_comb begin
      eff_req = client_req & ~mask;
      if (eff_req == 4'b0000) begin
         eff_req = client_req;
      end
   end

   // Sorted scan first; a stale or duplicated list falls back to the lowest set bit.
   always_comb begin
      winner = 2'd0;
      hit    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!hit && eff_req[sorted_addr[i]]) begin
            hit    = 1'b1;
            winner = sorted_addr[i];
         end
      end
      if (!hit) begin
         for (int i = 3; i >= 0; i--) begin
            if (eff_req[i]) begin
               winner = 2'(i);
            end
         end
      end
   end

   always_comb begin
      state_next       = state;
      hold_cnt_next    = hold_cnt;
      mask_next        = mask;
      grant_next       = grant;
      grant_valid_next = grant_valid;
      grant_addr_next  = grant_addr;
      timeout_next     = 1'b0;
      case (state)
         IDLE: begin
            if (eff_req != 4'b0000) begin
               state_next       = GRANT;
               grant_next       = 4'b0001 << winner;
               grant_addr_next  = winner;
               grant_valid_next = 1'b1;
               hold_cnt_next    = '0;
               mask_next        = 4'b0000;
            end
         end
         GRANT: begin
            hold_cnt_next = hold_cnt + 1'b1;
            // Release takes precedence over the hold limit, so no mask is set then.
            if (!client_req[grant_addr]) begin
               state_next       = TURN;
               grant_next       = 4'b0000;
               grant_valid_next = 1'b0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next       = TURN;
               grant_next       = 4'b0000;
               grant_valid_next = 1'b0;
               timeout_next     = 1'b1;
               mask_next        = 4'b0001 << grant_addr;
            end
         end
         TURN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         mask        <= 4'b0000;
         grant       <= 4'b0000;
         grant_valid <= 1'b0;
         grant_addr  <= 2'd0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_next;
         hold_cnt    <= hold_cnt_next;
         mask        <= mask_next;
         grant       <= grant_next;
         grant_valid <= grant_valid_next;
         grant_addr  <= grant_addr_next;
         timeout     <= timeout_next;
      end
   end

endmodule
